// File: rtl/pwm_capture.sv
// PWM period / active-time capture, results in "cycles minus one" encoding.
// Optional glitch filter on the synchronised input: define PWM_CAPTURE_FILTER_EN.
`timescale 1ns/1ps
module pwm_capture #(
    parameter bit POLARITY    = 1'b1,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pwm_in,
    input  logic             capture_enable,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] half_o,
    output logic [CNT_W-1:0] period_count_o,
    output logic             result_valid_o,
    output logic             timeout_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   s;
    logic                   s_dly_q;
    logic                   ae;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hi_q;
    logic [CNT_W-1:0]       period_q;
    logic [CNT_W-1:0]       half_q;
    logic [CNT_W-1:0]       count_q;
    logic                   valid_q;
    logic                   timeout_q;
    logic                   busy_q;
    logic                   en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {SYNC_STAGES{~POLARITY}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Level is accepted once the current sample and the two before it agree.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= {2{~POLARITY}};
            filt_q <= ~POLARITY;
        end else begin
            hist_q <= {hist_q[0], sync_out};
            if (sync_out == hist_q[0] && sync_out == hist_q[1]) begin
                filt_q <= sync_out;
            end
        end
    end

    assign s = filt_q;
`else
    assign s = sync_out;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_dly_q <= ~POLARITY;
        end else begin
            s_dly_q <= s;
        end
    end

    assign ae = (s == POLARITY) && (s_dly_q != POLARITY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            half_q    <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            en_q      <= capture_enable;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            // Disable overrides everything, including a coincident active edge.
            if (!capture_enable) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                hi_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        hi_q  <= '0;
                        if (!en_q) begin
                            count_q <= '0;
                            state_q <= WAIT_EDGE;
                        end
                    end
                    WAIT_EDGE: begin
                        if (ae) begin
                            cnt_q   <= '0;
                            hi_q    <= '0;
                            state_q <= MEASURE;
                            busy_q  <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (ae) begin
                            period_q <= cnt_q;
                            half_q   <= hi_q;
                            valid_q  <= 1'b1;
                            count_q  <= count_q + CNT_W'(1);
                            cnt_q    <= '0;
                            hi_q     <= '0;
                        end else if (&cnt_q) begin
                            timeout_q <= 1'b1;
                            state_q   <= WAIT_EDGE;
                            busy_q    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (s == POLARITY) begin
                                hi_q <= hi_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period_o       = period_q;
    assign half_o         = half_q;
    assign period_count_o = count_q;
    assign result_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = busy_q;
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receiver-side counterpart of the team's PWM generator model.
- Samples an external PWM waveform on the system clock and measures each complete period.
- Reports period and active-time values in the same "cycles minus one" encoding the generator takes as pwm_period / pwm_half, so generator settings can be checked directly against captured values.
- Counts completed periods and flags a stalled input.

Parameters:
- POLARITY, 1, active level of pwm_in; the active edge is the transition into this level.
- CNT_W, 16, width of all counters and result registers.
- SYNC_STAGES, 2, flop stages in the pwm_in synchroniser (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rstn  input  1  asynchronous active-low reset; release is synchronous to clk.
- pwm_in  input  1  asynchronous PWM input.
- capture_enable  input  1  level; high = capture running.
- period_o  output  CNT_W  last measured period, encoded as cycles-1.
- half_o  output  CNT_W  last measured active time, encoded as cycles-1.
- period_count_o  output  CNT_W  complete periods measured since the enable rising edge.
- result_valid_o  output  1  one-cycle pulse when period_o / half_o update.
- timeout_o  output  1  one-cycle pulse when no active edge arrives within 2^CNT_W cycles.
- busy_o  output  1  high while state is MEASURE.

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops cleared to ~POLARITY.
- Synchroniser and edge detection:
  - pwm_in passes through SYNC_STAGES flops; the result is s.
  - s_d is s delayed one cycle.
  - Active edge (ae) = (s == POLARITY) && (s_d != POLARITY).
  - Input-to-ae latency: SYNC_STAGES+1 cycles.
- States:
  - IDLE: counters held at 0. capture_enable rising edge -> clear period_count_o, go to WAIT_EDGE.
  - WAIT_EDGE: on ae -> cnt<=0, hi<=0, go to MEASURE. A waveform already in the active level at enable does not start a measurement.
  - MEASURE:
    - Each cycle without ae: cnt<=cnt+1; hi<=hi+1 if s==POLARITY, else hi holds.
    - On ae: period_o<=cnt, half_o<=hi, result_valid_o=1 in the following cycle (registered), period_count_o+=1, cnt<=0, hi<=0, stay in MEASURE.
  - capture_enable low in any state -> IDLE next cycle. Results and period_count_o are held; no pulse is generated.
- Encoding check: a generator active for half+1 cycles in a period of period+1 cycles yields half_o=half and period_o=period.
- Timeout: in MEASURE with cnt==all-ones and no ae:
  - timeout_o pulses for one cycle.
  - Go to WAIT_EDGE; results and count are unchanged.
  - WAIT_EDGE itself never times out.
- Constant-active input (100% duty): no ae after the first, so this ends in timeout.
- period_count_o wraps from all-ones to 0 silently.
- ae on the same cycle as enable falling: enable wins; no update, state -> IDLE.
- Reset asserted mid-measurement: immediate return to reset values.
- busy_o = (state==MEASURE), registered.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A 3-cycle glitch filter sits between the synchroniser and s.
  - The filtered level changes only after the synchroniser output has been stable for 3 consecutive cycles.
  - Pulses or gaps shorter than 3 cycles are ignored.
  - Input-to-ae latency grows by 3 cycles.
  - Measured values are unchanged for clean waveforms.
- Undefined: s is the synchroniser output directly; no filter logic is present.

Test Plan:
- Generator on the same clk with period=127, half=63, POLARITY=1, enable capture first -> after the second active edge, period_o=127, half_o=63, result_valid_o pulses once per period, period_count_o increments 1,2,3...
- Generator period_number=4, then output returns idle (0) -> exactly 3 result_valid_o pulses, then timeout_o pulses once 65536 cycles after the last active edge, period_count_o=3, busy_o drops.
- POLARITY=0 instance, generator POLARITY=0, period=9, half=2 -> period_o=9, half_o=2.
- Deassert capture_enable mid-period after 2 results, reassert -> results held while disabled; period_count_o=0 on re-enable; no result until 2 further active edges.
- pwm_in held high at enable, then waveform period=15, half=7 -> first active edge is not a measurement; first result period_o=15, half_o=7.
- With PWM_CAPTURE_FILTER_EN: 1-cycle low glitch injected inside the active phase of period=31, half=15 -> period_o=31, half_o=15 unaffected; without the macro, the glitch produces a spurious short result.
